// File: rtl/service_alarm_multi_set_pkg.sv
`default_nettype none
// ============================================================================
// Module      : service_alarm_multi_set_pkg
// Description : Shared definitions for the multi-slot alarm setting service.
//               Contains the controller state encoding, the cursor digit
//               positions, the BCD limit of each digit and a helper that
//               returns the limit of the digit under the cursor.
// Revision    : 1.0 - initial release
// ============================================================================
package service_alarm_multi_set_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Digit limits of a 24-hour HH:MM value
  localparam logic [3:0] HT_MAX    = 4'd2;
  localparam logic [3:0] HO_MAX    = 4'd9;
  localparam logic [3:0] HO_MAX_20 = 4'd3;  // hours ones when hours tens is 2
  localparam logic [3:0] MT_MAX    = 4'd5;
  localparam logic [3:0] MO_MAX    = 4'd9;

  // Cursor positions; the value is also the nibble index inside {Ht,Ho,Mt,Mo}
  localparam logic [1:0] CUR_HT = 2'd3;
  localparam logic [1:0] CUR_HO = 2'd2;
  localparam logic [1:0] CUR_MT = 2'd1;
  localparam logic [1:0] CUR_MO = 2'd0;

  // Largest legal value of the digit at 'cursor' given the current hours tens
  function automatic logic [3:0] digit_max(input logic [1:0] cursor,
                                           input logic [3:0] ht);
    logic [3:0] m;
    case (cursor)
      CUR_HT:  m = HT_MAX;
      CUR_HO:  m = (ht == HT_MAX) ? HO_MAX_20 : HO_MAX;
      CUR_MT:  m = MT_MAX;
      CUR_MO:  m = MO_MAX;
      default: m = MO_MAX;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_step
// Description : Combinational up/down step of one BCD digit with wrap-around
//               between 0 and a programmable maximum.
// Ports       : digit - current digit value
//               max   - largest legal value of this digit
//               up    - increment request
//               down  - decrement request (up and down together: no change)
//               next  - resulting digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_step (
  input  logic [3:0] digit,
  input  logic [3:0] max,
  input  logic       up,
  input  logic       down,
  output logic [3:0] next
);

  always_comb begin
    next = digit;
    if (up && !down) begin
      next = (digit >= max) ? 4'd0 : digit + 4'd1;
    end else if (down && !up) begin
      // An out-of-range digit is pulled back to the maximum on a decrement
      next = (digit == 4'd0 || digit > max) ? max : digit - 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/service_alarm_multi_set.sv
`default_nettype none
// ============================================================================
// Module      : service_alarm_multi_set
// Description : NUM_ALARMS-slot BCD HH:MM alarm store with cursor-based
//               digit editing and a rising-edge match detector.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               spdt            - edit switch (rise enters edit, fall commits)
//               push_u/d/l/r    - digit up/down, cursor left/right
//               push_c          - toggle enable of slot_sel while idle
//               slot_sel        - slot to edit/view
//               set_time        - running time {Ht,Ho,Mt,Mo}
//               an              - active-low cursor indicator (blinking)
//               num             - edit buffer while editing, else set_time
//               alarm           - stored value of slot_sel
//               alarm_en        - per-slot enable bits
//               finish          - one-cycle commit pulse
//               alarm_hit       - one-cycle pulse on a new match
//               hit_slot        - lowest matching slot, valid with alarm_hit
// Revision    : 1.0 - initial release
// ============================================================================
module service_alarm_multi_set
  import service_alarm_multi_set_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int SLOT_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  parameter int BLINK_CYC  = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spdt,
  input  logic                  push_u,
  input  logic                  push_d,
  input  logic                  push_l,
  input  logic                  push_r,
  input  logic                  push_c,
  input  logic [SLOT_W-1:0]     slot_sel,
  input  logic [15:0]           set_time,
  output logic [3:0]            an,
  output logic [15:0]           num,
  output logic [15:0]           alarm,
  output logic [NUM_ALARMS-1:0] alarm_en,
  output logic                  finish,
  output logic                  alarm_hit,
  output logic [SLOT_W-1:0]     hit_slot
);

  localparam int               CNT_W    = $clog2(BLINK_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYC - 1);

  state_t                r_state, w_state_nxt;
  logic                  r_spdt_q, r_pend;
  logic                  w_rise, w_fall;
  logic [SLOT_W-1:0]     r_edit_slot;
  logic [15:0]           r_buf;
  logic [1:0]            r_cursor;
  logic [CNT_W-1:0]      r_blink_cnt;
  logic                  r_blink_on;
  logic [15:0]           r_slot [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_en;
  logic [15:0]           w_sel_val, w_buf_edit;
  logic [3:0]            w_digit, w_max, w_next;
  logic [NUM_ALARMS-1:0] w_match;
  logic [SLOT_W-1:0]     w_low;
  logic                  r_match_any, r_hit;
  logic [SLOT_W-1:0]     r_hit_slot;

  assign w_rise = spdt & ~r_spdt_q;
  assign w_fall = ~spdt & r_spdt_q;

  // Slot read; an index beyond NUM_ALARMS reads as zero
  always_comb begin
    w_sel_val = 16'h0000;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (SLOT_W'(i) == slot_sel) w_sel_val = r_slot[i];
    end
  end

  // Single digit stepper shared by all four positions through the cursor mux
  assign w_digit = r_buf[{r_cursor, 2'b00} +: 4];
  assign w_max   = digit_max(r_cursor, r_buf[15:12]);

  bcd_digit_step u_step (
    .digit (w_digit),
    .max   (w_max),
    .up    (push_u),
    .down  (push_d),
    .next  (w_next)
  );

  always_comb begin
    w_buf_edit = r_buf;
    w_buf_edit[{r_cursor, 2'b00} +: 4] = w_next;
    // Moving hours tens to 2 must keep the hour legal (20..23)
    if (r_cursor == CUR_HT && w_next == HT_MAX && r_buf[11:8] > HO_MAX_20) begin
      w_buf_edit[11:8] = HO_MAX_20;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    finish      = 1'b0;
    an          = 4'b1111;
    num         = set_time;
    case (r_state)
      ST_IDLE: begin
        if (w_rise || r_pend) w_state_nxt = ST_EDIT;
      end
      ST_EDIT: begin
        num = r_buf;
        if (r_blink_on) an = ~(4'b0001 << r_cursor);
        if (w_fall) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        num         = r_buf;
        finish      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_spdt_q    <= 1'b0;
      r_pend      <= 1'b0;
      r_edit_slot <= '0;
      r_buf       <= 16'h0000;
      r_cursor    <= CUR_HT;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_en        <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) r_slot[i] <= 16'h0000;
    end else begin
      r_spdt_q <= spdt;
      case (r_state)
        ST_IDLE: begin
          r_pend <= 1'b0;
          if (w_rise || r_pend) begin
            r_edit_slot <= slot_sel;
            r_buf       <= w_sel_val;
            r_cursor    <= CUR_HT;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
          end
          if (push_c) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
              if (SLOT_W'(i) == slot_sel) r_en[i] <= ~r_en[i];
            end
          end
        end
        ST_EDIT: begin
          if (r_blink_cnt == CNT_LAST) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
          end else begin
            r_blink_cnt <= r_blink_cnt + CNT_W'(1);
          end
          // Value change uses the old cursor; the move lands afterwards
          if (!w_fall) begin
            r_buf <= w_buf_edit;
            if (push_l && !push_r)      r_cursor <= r_cursor + 2'd1;
            else if (push_r && !push_l) r_cursor <= r_cursor - 2'd1;
          end
        end
        ST_COMMIT: begin
          // spdt_q is low here, so any high spdt is a fresh rise to replay
          r_pend <= w_rise;
          for (int i = 0; i < NUM_ALARMS; i++) begin
            if (SLOT_W'(i) == r_edit_slot) begin
              r_slot[i] <= r_buf;
              r_en[i]   <= 1'b1;
            end
          end
        end
        default: r_pend <= 1'b0;
      endcase
    end
  end

  // ------------------------------------------------------------- match
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      w_match[i] = r_en[i] && (r_slot[i] == set_time);
    end
  end

  always_comb begin
    w_low = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (w_match[i]) w_low = SLOT_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_match_any <= 1'b0;
      r_hit       <= 1'b0;
      r_hit_slot  <= '0;
    end else begin
      r_match_any <= |w_match;
      r_hit       <= (|w_match) & ~r_match_any;
      if ((|w_match) && !r_match_any) r_hit_slot <= w_low;
    end
  end

  assign alarm     = w_sel_val;
  assign alarm_en  = r_en;
  assign alarm_hit = r_hit;
  assign hit_slot  = r_hit_slot;

endmodule
`default_nettype wire

// File: tb/tb_service_alarm_multi_set.sv
`default_nettype none
// ============================================================================
// Module      : tb_service_alarm_multi_set
// Description : Self-checking bench for service_alarm_multi_set with a
//               digit-array reference model of the edit buffer, cursor,
//               blink phase, slot store and alarm match pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_service_alarm_multi_set;

  localparam int NA = 4;
  localparam int SW = 2;
  localparam int BC = 4;

  logic          clk = 1'b0;
  logic          reset, spdt, push_u, push_d, push_l, push_r, push_c;
  logic [SW-1:0] slot_sel;
  logic [15:0]   set_time;
  logic [3:0]    an;
  logic [15:0]   num, alarm;
  logic [NA-1:0] alarm_en;
  logic          finish, alarm_hit;
  logic [SW-1:0] hit_slot;

  always #5 clk = ~clk;

  service_alarm_multi_set #(.NUM_ALARMS(NA), .SLOT_W(SW), .BLINK_CYC(BC)) dut (
    .clk(clk), .reset(reset), .spdt(spdt),
    .push_u(push_u), .push_d(push_d), .push_l(push_l), .push_r(push_r),
    .push_c(push_c), .slot_sel(slot_sel), .set_time(set_time),
    .an(an), .num(num), .alarm(alarm), .alarm_en(alarm_en),
    .finish(finish), .alarm_hit(alarm_hit), .hit_slot(hit_slot)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: digits indexed 3=Ht..0=Mo, cursor, edit-cycle count
  logic [15:0]   m_slot [NA];
  logic [NA-1:0] m_en;
  int            m_dig [4];
  int            m_cur, m_k, m_es;

  function automatic int lim(int c);
    if (c == 3) return 2;
    if (c == 2) return (m_dig[3] == 2) ? 3 : 9;
    if (c == 1) return 5;
    return 9;
  endfunction

  function automatic logic [15:0] m_buf();
    return {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] one;
    one = 4'b0001;
    if (((m_k / BC) % 2) == 0) return ~(one << m_cur);
    return 4'b1111;
  endfunction

  task automatic m_step(input bit u, input bit d, input bit l, input bit r);
    int c;
    c = m_cur;
    if (u && !d)      m_dig[c] = (m_dig[c] >= lim(c)) ? 0 : m_dig[c] + 1;
    else if (d && !u) m_dig[c] = (m_dig[c] == 0) ? lim(c) : m_dig[c] - 1;
    if (c == 3 && m_dig[3] == 2 && m_dig[2] > 3) m_dig[2] = 3;
    if (l && !r)      m_cur = (m_cur + 1) % 4;
    else if (r && !l) m_cur = (m_cur + 3) % 4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_k++;
  endtask

  task automatic enter(input int s);
    slot_sel = SW'(s);
    spdt = 1'b1;
    tick();
    m_es = s; m_cur = 3; m_k = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = int'((m_slot[s] >> (4 * i)) & 16'h000F);
  endtask

  task automatic press(input bit u, input bit d, input bit l, input bit r);
    push_u = u; push_d = d; push_l = l; push_r = r;
    tick();
    push_u = 0; push_d = 0; push_l = 0; push_r = 0;
    m_step(u, d, l, r);
  endtask

  // Falls spdt; returns finish/an in the commit cycle and finish one cycle later
  task automatic leave(output logic f_c, output logic [3:0] an_c, output logic f_a);
    spdt = 1'b0;
    tick();
    f_c = finish; an_c = an;
    tick();
    f_a = finish;
    m_slot[m_es] = m_buf();
    m_en[m_es]   = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1; spdt = 0; push_u = 0; push_d = 0; push_l = 0; push_r = 0; push_c = 0;
    slot_sel = '0; set_time = 16'h1630;
    repeat (3) tick();
    checks++; if (an !== 4'b1111)   begin failures++; $display("FAIL reset_an got=%b exp=1111", an); end
    checks++; if (finish !== 1'b0)  begin failures++; $display("FAIL reset_finish got=%b exp=0", finish); end
    checks++; if (alarm_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", alarm_hit); end
    checks++; if (hit_slot !== '0)  begin failures++; $display("FAIL reset_hit_slot got=%0d exp=0", hit_slot); end
    checks++; if (num !== 16'h1630) begin failures++; $display("FAIL reset_num got=%h exp=1630", num); end
    checks++; if (alarm_en !== '0)  begin failures++; $display("FAIL reset_en got=%b exp=0", alarm_en); end
    reset = 0;
    tick();
    for (int i = 0; i < NA; i++) begin
      m_slot[i] = 16'h0000;
      slot_sel = SW'(i);
      #1;
      checks++; if (alarm !== 16'h0000) begin failures++; $display("FAIL reset_slot%0d got=%h exp=0000", i, alarm); end
    end
    m_en = '0;
  endtask

  task automatic test_reset_mid_edit();
    bit seen_fin;
    enter(0);
    press(1, 0, 0, 0); press(0, 0, 0, 1); press(1, 0, 0, 0); press(1, 0, 0, 0);
    checks++; if (num !== 16'h1200 || num !== m_buf()) begin failures++; $display("FAIL midedit_buf got=%h exp=1200", num); end
    seen_fin = 0;
    reset = 1;
    tick();
    if (finish) seen_fin = 1;
    checks++; if (an !== 4'b1111) begin failures++; $display("FAIL midedit_an got=%b exp=1111", an); end
    checks++; if (num !== set_time) begin failures++; $display("FAIL midedit_num got=%h exp=%h", num, set_time); end
    spdt = 0; reset = 0;
    repeat (3) begin tick(); if (finish) seen_fin = 1; end
    checks++; if (seen_fin !== 1'b0) begin failures++; $display("FAIL midedit_finish got=1 exp=0"); end
    slot_sel = '0; #1;
    checks++; if (alarm !== 16'h0000) begin failures++; $display("FAIL midedit_slot got=%h exp=0000", alarm); end
    checks++; if (alarm_en !== '0) begin failures++; $display("FAIL midedit_en got=%b exp=0", alarm_en); end
  endtask

  task automatic test_edit_basic();
    set_time = 16'h1630;
    enter(0);
    press(0, 0, 0, 1); press(0, 1, 0, 0); press(0, 0, 0, 1);
    repeat (3) press(1, 0, 0, 0);
    press(0, 0, 0, 1); press(0, 1, 0, 0); press(0, 1, 0, 0);
    checks++; if (num !== 16'h0938 || num !== m_buf()) begin failures++; $display("FAIL basic_buf got=%h exp=0938", num); end
    spdt = 0; push_u = 1;   // push in the falling cycle must be ignored
    tick();
    push_u = 0;
    checks++; if (finish !== 1'b1) begin failures++; $display("FAIL basic_finish got=%b exp=1", finish); end
    checks++; if (num !== 16'h0938) begin failures++; $display("FAIL basic_fallpush got=%h exp=0938", num); end
    tick();
    m_slot[0] = m_buf(); m_en[0] = 1;
    checks++; if (finish !== 1'b0) begin failures++; $display("FAIL basic_finish_once got=%b exp=0", finish); end
    checks++; if (alarm !== 16'h0938) begin failures++; $display("FAIL basic_slot0 got=%h exp=0938", alarm); end
    checks++; if (alarm_en[0] !== 1'b1) begin failures++; $display("FAIL basic_en0 got=%b exp=1", alarm_en[0]); end
    checks++; if (num !== 16'h1630) begin failures++; $display("FAIL basic_num got=%h exp=1630", num); end
  endtask

  task automatic test_clamp();
    logic f_c, f_a; logic [3:0] an_c;
    enter(2);
    press(0, 0, 0, 1); press(0, 1, 0, 0); press(0, 0, 1, 0);
    press(1, 0, 0, 0); press(1, 0, 0, 0);
    checks++; if (num !== 16'h2300 || num !== m_buf()) begin failures++; $display("FAIL clamp_ho got=%h exp=2300", num); end
    press(0, 0, 0, 1); press(1, 0, 0, 0);
    checks++; if (num !== 16'h2000) begin failures++; $display("FAIL clamp_wrap got=%h exp=2000", num); end
    leave(f_c, an_c, f_a);
    checks++; if (f_c !== 1'b1 || f_a !== 1'b0) begin failures++; $display("FAIL clamp_finish got=%b%b exp=10", f_c, f_a); end
    slot_sel = 2'd2; #1;
    checks++; if (alarm !== 16'h2000) begin failures++; $display("FAIL clamp_slot2 got=%h exp=2000", alarm); end
  endtask

  task automatic test_wrap();
    logic f_c, f_a; logic [3:0] an_c;
    enter(3);
    press(0, 0, 1, 0);
    checks++; if (an !== 4'b1110 || an !== exp_an()) begin failures++; $display("FAIL wrap_left got=%b exp=1110", an); end
    press(0, 0, 1, 0); press(0, 1, 0, 0);
    checks++; if (num !== 16'h0050) begin failures++; $display("FAIL wrap_mt got=%h exp=0050", num); end
    press(0, 0, 1, 0); press(0, 0, 1, 0);
    repeat (3) press(1, 0, 0, 0);
    press(1, 1, 0, 0);
    checks++; if (num !== 16'h0050 || num !== m_buf()) begin failures++; $display("FAIL wrap_ht got=%h exp=0050", num); end
    press(1, 0, 0, 1);      // step Ht at old cursor, then move to Ho
    press(0, 1, 1, 1);      // both moves: stay on Ho, Ho 0 -> 9
    checks++; if (num !== 16'h1950 || num !== m_buf()) begin failures++; $display("FAIL wrap_combo got=%h exp=1950", num); end
    checks++; if (an !== exp_an()) begin failures++; $display("FAIL wrap_cursor got=%b exp=%b", an, exp_an()); end
    leave(f_c, an_c, f_a);
    slot_sel = 2'd3; #1;
    checks++; if (alarm !== 16'h1950) begin failures++; $display("FAIL wrap_slot3 got=%h exp=1950", alarm); end
  endtask

  task automatic test_blink();
    logic f_c, f_a; logic [3:0] an_c;
    enter(1);
    checks++; if (an !== 4'b0111) begin failures++; $display("FAIL blink_first got=%b exp=0111", an); end
    for (int j = 0; j < 12; j++) begin
      tick();
      checks++; if (an !== exp_an()) begin failures++; $display("FAIL blink_k%0d got=%b exp=%b", m_k, an, exp_an()); end
    end
    leave(f_c, an_c, f_a);
    checks++; if (an_c !== 4'b1111) begin failures++; $display("FAIL blink_commit_an got=%b exp=1111", an_c); end
    checks++; if (an !== 4'b1111) begin failures++; $display("FAIL blink_idle_an got=%b exp=1111", an); end
  endtask

  task automatic test_back_to_back();
    logic f_c, f_a; logic [3:0] an_c;
    enter(1);
    press(0, 0, 0, 1);
    repeat (7) press(1, 0, 0, 0);
    spdt = 0;
    tick();
    checks++; if (finish !== 1'b1) begin failures++; $display("FAIL b2b_finish got=%b exp=1", finish); end
    spdt = 1;                  // rising during the commit cycle
    tick();
    m_slot[1] = m_buf(); m_en[1] = 1;
    checks++; if (num !== set_time || an !== 4'b1111) begin failures++; $display("FAIL b2b_idle got=%h/%b exp=%h/1111", num, an, set_time); end
    tick();
    m_es = 1; m_cur = 3; m_k = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = int'((m_slot[1] >> (4 * i)) & 16'h000F);
    checks++; if (num !== 16'h0700 || an !== 4'b0111) begin failures++; $display("FAIL b2b_reenter got=%h/%b exp=0700/0111", num, an); end
    slot_sel = 2'd2;           // ignored while editing
    press(1, 0, 0, 0); press(0, 1, 0, 0);
    leave(f_c, an_c, f_a);
    slot_sel = 2'd1; #1;
    checks++; if (alarm !== 16'h0700) begin failures++; $display("FAIL b2b_slot1 got=%h exp=0700", alarm); end
    slot_sel = 2'd2; #1;
    checks++; if (alarm !== 16'h2000) begin failures++; $display("FAIL b2b_slot2 got=%h exp=2000", alarm); end
  endtask

  task automatic test_match();
    set_time = 16'h0659;
    tick(); tick();
    checks++; if (alarm_hit !== 1'b0) begin failures++; $display("FAIL match_pre got=%b exp=0", alarm_hit); end
    set_time = 16'h0700;
    tick();
    checks++; if (alarm_hit !== 1'b1) begin failures++; $display("FAIL match_hit got=%b exp=1", alarm_hit); end
    checks++; if (hit_slot !== 2'd1) begin failures++; $display("FAIL match_slot got=%0d exp=1", hit_slot); end
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++; if (alarm_hit !== 1'b0) begin failures++; $display("FAIL match_hold%0d got=%b exp=0", j, alarm_hit); end
    end
    slot_sel = 2'd1; push_c = 1;
    tick();
    push_c = 0; m_en[1] = 0;
    checks++; if (alarm_en[1] !== 1'b0) begin failures++; $display("FAIL match_disable got=%b exp=0", alarm_en[1]); end
    set_time = 16'h0659; tick();
    set_time = 16'h0700;
    for (int j = 0; j < 2; j++) begin
      tick();
      checks++; if (alarm_hit !== 1'b0) begin failures++; $display("FAIL match_off%0d got=%b exp=0", j, alarm_hit); end
    end
  endtask

  task automatic test_random_match();
    bit prev, any, pc;
    int low, sel, pick;
    set_time = 16'h2359;
    tick(); tick();
    prev = 0;
    for (int n = 0; n < 80; n++) begin
      pick = int'($urandom_range(0, 5));
      if (pick < NA)       set_time = m_slot[pick];
      else if (pick == NA) set_time = 16'h2359;
      else                 set_time = 16'($urandom);
      pc  = ($urandom_range(0, 3) == 0);
      sel = int'($urandom_range(0, NA - 1));
      slot_sel = SW'(sel); push_c = pc;
      any = 0; low = 0;
      for (int i = NA - 1; i >= 0; i--) begin
        if (m_en[i] && m_slot[i] == set_time) begin any = 1; low = i; end
      end
      tick();
      push_c = 0;
      checks++; if (alarm_hit !== (any && !prev)) begin failures++; $display("FAIL rand_hit n=%0d got=%b exp=%b", n, alarm_hit, any && !prev); end
      if (any && !prev) begin
        checks++; if (hit_slot !== SW'(low)) begin failures++; $display("FAIL rand_slot n=%0d got=%0d exp=%0d", n, hit_slot, low); end
      end
      prev = any;
      if (pc) m_en[sel] = ~m_en[sel];
      checks++; if (alarm_en !== m_en) begin failures++; $display("FAIL rand_en n=%0d got=%b exp=%b", n, alarm_en, m_en); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_edit();
    test_edit_basic();
    test_clamp();
    test_wrap();
    test_blink();
    test_back_to_back();
    test_match();
    test_random_match();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/service_alarm_multi_set.md
Name: service_alarm_multi_set

Overview:
Parametrised successor to the single-alarm setting service. Holds NUM_ALARMS BCD HH:MM alarm slots, each with an enable bit. Edits the selected slot digit-by-digit with the push buttons under a cursor, enforcing 24-hour digit limits. Compares the running set_time against all enabled slots and pulses on a match; sits between the button-strobe logic and the 7-segment display/buzzer path.

Parameters:
NUM_ALARMS, 4, number of alarm slots (1..8)
SLOT_W, $clog2(NUM_ALARMS) min 1, slot index width (derived)
BLINK_CYC, 25_000_000, clk cycles per cursor blink half-period (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
spdt  in  1  edit switch: 1 = edit selected slot, falling edge commits
push_u  in  1  increment cursor digit; one action per cycle high
push_d  in  1  decrement cursor digit; one action per cycle high
push_l  in  1  move cursor left; one action per cycle high
push_r  in  1  move cursor right; one action per cycle high
push_c  in  1  toggle enable of slot_sel, honoured only in IDLE
slot_sel  in  SLOT_W  slot to edit/view
set_time  in  16  current time, BCD {Ht,Ho,Mt,Mo}
an  out  4  active-low cursor anode indicator
num  out  16  display value: edit buffer in EDIT, else set_time
alarm  out  16  stored value of slot_sel
alarm_en  out  NUM_ALARMS  per-slot enable bits
finish  out  1  one-cycle commit pulse
alarm_hit  out  1  one-cycle pulse on new match
hit_slot  out  SLOT_W  lowest matching enabled slot, valid with alarm_hit

Behaviour:
- Reset (sync, active-high): all slots 16'h0000, alarm_en=0, state IDLE, cursor=3, buf=0, blink counter 0; an=4'b1111, finish=0, alarm_hit=0, hit_slot=0, num=set_time.
- FSM IDLE -> EDIT on spdt 0->1 (registered spdt detects edges); on entry latch slot_sel into edit_slot, buf<=slot[edit_slot], cursor<=3 (Ht), blink phase on. slot_sel changes during EDIT are ignored.
- EDIT -> COMMIT on spdt 1->0; pushes in that cycle are ignored. COMMIT lasts one cycle: finish=1, slot[edit_slot]<=buf, alarm_en[edit_slot]<=1, then IDLE. A new rising spdt during COMMIT is taken in IDLE next cycle.
- Cursor index 3=Ht,2=Ho,1=Mt,0=Mo. push_r: cursor-1, 0 wraps to 3. push_l: cursor+1, 3 wraps to 0. Both high: no move.
- Digit limits: Ht 0..2; Ho 0..9, or 0..3 when Ht=2; Mt 0..5; Mo 0..9. push_u at max wraps to 0; push_d at 0 wraps to max. push_u and push_d both high: no change. Move and up/down in the same cycle: apply value change at old cursor, then move.
- Changing Ht to 2 while Ho>3 clamps Ho to 3 in the same cycle.
- an: in EDIT, ~(4'b0001<<cursor) during blink-on phase, 4'b1111 during blink-off; blink counter toggles phase every BLINK_CYC cycles. IDLE/COMMIT: 4'b1111.
- num: buf in EDIT and COMMIT; set_time otherwise. alarm: combinational read slot[slot_sel].
- push_c in IDLE toggles alarm_en[slot_sel]; ignored in EDIT/COMMIT.
- Match: match_vec[i]=alarm_en[i] && slot[i]==set_time. Registered once; alarm_hit=1 for one cycle when |match_vec rises from 0 (no retrigger while match holds). hit_slot = lowest set index, registered with alarm_hit. Slot being edited still matches on its stored value, not buf.
- Reset mid-edit discards buf; no finish.

Decomposition:
- Shared package: BCD digit-limit constants (HT_MAX=2, HO_MAX=9, HO_MAX_20=3, MT_MAX=5, MO_MAX=9), state encoding IDLE/EDIT/COMMIT, cursor index constants.
- One sub-module: bcd_digit_step (combinational: digit, max, up, down -> next digit), instanced per field or once at cursor mux.

Test Plan:
- Reset, spdt=1, slot 0; r, d x1, r, u x3 (held 3 cycles), r, d x2, spdt=0 -> finish pulse one cycle; alarm(slot0)=16'h0938, alarm_en[0]=1; num=set_time 16'h1630.
- Slot 2 edit: Ht u x2 (=2), then Ho from buffer 9 -> Ho clamped to 3; u on Ho -> 0; commit -> slot2=16'h2000.
- Wrap: cursor l at 3 -> 0; d on Mt=0 -> 5; u on Ht=2 -> 0; u and d same cycle -> unchanged.
- Match: slot1=16'h0700 enabled; set_time steps 0659->0700 -> alarm_hit=1 exactly one cycle, hit_slot=1; held 0700 -> no repeat; push_c disables slot1 -> no hit on next match.
- Reset asserted mid-edit after buf=16'h1200 -> slot unchanged 0000, finish never pulses, an=4'b1111.
- BLINK_CYC=4: in EDIT, cursor=3 -> an alternates 4'b0111/4'b1111 every 4 cycles; after spdt fall, an=4'b1111.
